// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that grants one byte-wide requester at a time and serializes its byte
// as a 10-bit UART frame (start, 8 data bits MSB first, stop) on a shared TX line.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [8*N_REQ-1:0]       req_data,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic                     tx
);

   localparam int unsigned IdxW = $clog2(N_REQ);
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q;
   logic [IdxW-1:0]   ptr_q;
   logic [7:0]        shift_q;
   logic [CntW-1:0]   baud_q;
   logic [2:0]        bit_q;
   logic [N_REQ-1:0]  gnt_q;
   logic [IdxW-1:0]   owner_q;
   logic              busy_q;
   logic              tx_q;

   logic              found;
   logic [IdxW-1:0]   sel;
   logic [IdxW-1:0]   cand;
   logic [IdxW-1:0]   ptr_next;
   logic              baud_last;

   // First set request scanning upward from ptr_q, wrapping at N_REQ.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = IdxW'((32'(ptr_q) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   assign ptr_next  = (sel == IdxW'(N_REQ - 1)) ? '0 : sel + IdxW'(1);
   assign baud_last = (baud_q == CntW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         shift_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         gnt_q   <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         gnt_q <= '0;
         unique case (state_q)
            StIdle: begin
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
               if (found) begin
                  gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
                  owner_q <= sel;
                  shift_q <= req_data[{sel, 3'b000} +: 8];
                  ptr_q   <= ptr_next;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  tx_q    <= shift_q[7];
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            StData: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     // shift_q[7] is the bit on the line, so the next one sits at [6].
                     bit_q   <= bit_q + 3'd1;
                     shift_q <= {shift_q[6:0], 1'b0};
                     tx_q    <= shift_q[6];
                  end
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            StStop: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  baud_q <= baud_q + CntW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = busy_q;
   assign tx    = tx_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and frame sequencer that shares one UART serial output line among `N_REQ` byte-wide requesters. It grants one requester at a time, latches that requester's byte, and serializes it as a 10-bit frame at a fixed baud set by a clock divider. It sits between on-chip byte producers and the board TX pin, and is the transmit-side counterpart of the team's UART receiver.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; must be ≥2.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  N_REQ  per-requester level request; bit i belongs to requester i.
- `req_data`  in  8*N_REQ  byte of requester i on `req_data[8*i+7:8*i]`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `owner`  out  $clog2(N_REQ)  index of the requester whose frame is in flight, or the last one served.
- `busy`  out  1  high while a frame is on the line.
- `tx`  out  1  serial output; idle high.

## Operation
- All outputs are registered.
- States: IDLE, START, DATA, STOP.
- Internal state:
  - rotating priority pointer `ptr`
  - 8-bit shift register
  - baud counter, 0..CLKS_PER_BIT-1
  - bit counter, 0..7
- IDLE:
  - `tx`=1, `busy`=0.
  - If `req` is nonzero, select the first set bit scanning `ptr`, `ptr`+1, …, wrapping mod N_REQ.
  - On that edge, for the selected index i:
    - `gnt[i]`<=1.
    - `owner`<=i.
    - Shift register <= `req_data` byte i.
    - `ptr`<=(i+1) mod N_REQ.
    - `tx`<=0, `busy`<=1, both counters <=0.
    - Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 data bits, MSB first (bit 7 first, bit 0 last), each held CLKS_PER_BIT cycles.
  - After bit 0, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE with `busy`<=0.
- `gnt` is high for exactly one cycle per frame and is 0 in every other cycle.
- Requester contract:
  - Hold `req` and the byte stable until `gnt` is seen.
  - Clear `req` in the `gnt` cycle, or keep it high to request another byte.
- `req` and `req_data` are sampled only in IDLE. Changes during a frame have no effect on that frame.
- A requester that keeps `req` high is re-arbitrated fairly against the others. It is served again only after every other active requester has had a turn.
- Reset:
  - Any edge with `rst_n`=0 forces the following, from any state: IDLE, `tx`=1, `busy`=0, `gnt`=0, `owner`=0, `ptr`=0, counters=0, shift register=0.
  - A frame in flight is truncated and not retried.

## Timing
- Grant latency: `req` is high and the FSM is in IDLE at edge E. Then `gnt`, `busy`=1 and `tx`=0 are all visible in the cycle after E.
- Frame duration: `busy` is high for exactly 10*CLKS_PER_BIT cycles.
- Bit k (start=0, data bits 1..8, stop=9) occupies cycles [k*CLKS_PER_BIT, (k+1)*CLKS_PER_BIT) after the grant edge.
- Back-to-back frames: at least one IDLE cycle (`tx`=1, `busy`=0) separates frames. Consecutive grants are therefore ≥10*CLKS_PER_BIT+1 cycles apart.
- Simultaneous requests are resolved in a single cycle. There is no extra arbitration latency.
- Reset released at edge R: the earliest grant is visible in the cycle after edge R+1.

## Test plan
- Single byte, CLKS_PER_BIT=4:
  - Stimulus: `req[0]`=1 with byte 0xA5.
  - Response: `gnt`=0001 for 1 cycle, `owner`=0.
  - `tx` = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - `busy` high for 40 cycles.
- All four requests asserted the cycle after reset, each held until its own `gnt`, bytes 0x11/0x22/0x33/0x44:
  - Grants in order 0,1,2,3, 41 cycles apart.
  - The serialized bytes match the bytes in that order.
- Fairness: `req[0]` and `req[2]` held permanently high → grants alternate 0,2,0,2,…; requester 0 is never granted twice in a row.
- Late data change: `req_data` byte 0 changed from 0xA5 to 0x00 in the cycle after `gnt` → the frame still carries 0xA5.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 for one edge during data bit 3, with `req[1]` pending.
  - Response: `tx`=1, `busy`=0, `owner`=0 in the next cycle.
  - After release, requester 1 receives a full, fresh frame.
- Wrap-around: `ptr` at 3 after serving requester 2, then requests on 3 and 0 together → 3 is granted first, then 0.
